// File: rtl/irq_pkg.sv
// Shared definitions for the MIPS interrupt controller: register word offsets
// and the arbitration FSM state encoding.
package irq_pkg;

  localparam logic [31:0] REG_MASK   = 32'd0;
  localparam logic [31:0] REG_MODE   = 32'd1;
  localparam logic [31:0] REG_PEND   = 32'd2;
  localparam logic [31:0] REG_STATUS = 32'd3;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_SERVICE = 1'b1
  } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-first priority encoder: returns whether any
// request is set and the index of the lowest set request.
module irq_prio_enc #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  // Scan downward so the lowest set index is the last one written
  always_comb begin
    any = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/mips_irq_ctrl.sv
// Interrupt controller between N_SRC peripheral lines and the MIPS INT bus.
// Define IRQ_SYNC_EN to add a 2-flop synchroniser on every irq_src bit.
module mips_irq_ctrl
  import irq_pkg::*;
#(
  parameter int  N_SRC  = 8,
  parameter int  OUT_W  = 5,
  parameter int  ADDR_W = 3,
  localparam int ID_W   = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_SRC-1:0]  irq_src,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [31:0]       bus_wd,
  output logic [31:0]       bus_rd,
  output logic [OUT_W-1:0]  int_out,
  output logic              irq_valid,
  output logic [ID_W-1:0]   irq_id,
  input  logic              irq_ack
);

  logic [N_SRC-1:0] src_s;
  logic [N_SRC-1:0] hist_r;
  logic [N_SRC-1:0] mask_r;
  logic [N_SRC-1:0] mode_r;
  logic [N_SRC-1:0] pend_r;
  logic [N_SRC-1:0] pend_nxt_s;
  logic [N_SRC-1:0] req_s;
  logic [N_SRC-1:0] w1c_s;
  logic [N_SRC-1:0] ack_vec_s;
  logic [OUT_W-1:0] int_out_r;
  logic [OUT_W-1:0] int_nxt_s;
  logic [31:0]      addr_s;
  logic [31:0]      rd_s;
  logic             wr_mask_s;
  logic             wr_mode_s;
  logic             wr_pend_s;
  logic             unused_wd_s;
  logic             enc_any_s;
  logic [ID_W-1:0]  enc_idx_s;
  logic             ack_fire_s;
  irq_state_e       state_r;
  irq_state_e       state_nxt_s;
  logic [ID_W-1:0]  irq_id_r;
  logic [ID_W-1:0]  id_nxt_s;
  logic             irq_valid_r;
  logic             valid_nxt_s;

`ifdef IRQ_SYNC_EN
  logic [N_SRC-1:0] sync1_r;
  logic [N_SRC-1:0] sync2_r;

  // Two-flop synchroniser for asynchronous peripheral lines
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= irq_src;
      sync2_r <= sync1_r;
    end
  end

  assign src_s = sync2_r;
`else
  assign src_s = irq_src;
`endif

  assign addr_s      = 32'(bus_addr);
  assign wr_mask_s   = bus_we & (addr_s == REG_MASK);
  assign wr_mode_s   = bus_we & (addr_s == REG_MODE);
  assign wr_pend_s   = bus_we & (addr_s == REG_PEND);
  assign unused_wd_s = ^(bus_wd >> N_SRC);
  assign req_s       = pend_r & mask_r;
  assign ack_fire_s  = (state_r == ST_SERVICE) & irq_ack;

  // Pending update: edge sources set on rising edge, set beats W1C/ack; level sources follow the line
  always_comb begin
    w1c_s      = '0;
    ack_vec_s  = '0;
    pend_nxt_s = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w1c_s[i]     = wr_pend_s & bus_wd[i];
      ack_vec_s[i] = ack_fire_s & (irq_id_r == ID_W'(i));
      if (mode_r[i]) begin
        pend_nxt_s[i] = (src_s[i] & ~hist_r[i]) | (pend_r[i] & ~(w1c_s[i] | ack_vec_s[i]));
      end else begin
        pend_nxt_s[i] = src_s[i];
      end
    end
  end

  // Fold requests onto the narrower core INT bus, source i onto line i % OUT_W
  always_comb begin
    int_nxt_s = '0;
    for (int k = 0; k < OUT_W; k++) begin
      for (int i = 0; i < N_SRC; i++) begin
        int_nxt_s[k] = int_nxt_s[k] | (req_s[i] & ((i % OUT_W) == k));
      end
    end
  end

  // Software-visible registers, edge history and the registered INT lines
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_r    <= '0;
      mode_r    <= '0;
      pend_r    <= '0;
      hist_r    <= '0;
      int_out_r <= '0;
    end else begin
      if (wr_mask_s) begin
        mask_r <= bus_wd[N_SRC-1:0];
      end else begin
        mask_r <= mask_r;
      end
      if (wr_mode_s) begin
        mode_r <= bus_wd[N_SRC-1:0];
      end else begin
        mode_r <= mode_r;
      end
      pend_r    <= pend_nxt_s;
      hist_r    <= src_s;
      int_out_r <= int_nxt_s;
    end
  end

  irq_prio_enc #(
    .N     (N_SRC),
    .IDX_W (ID_W)
  ) u_prio_enc (
    .req (req_s),
    .any (enc_any_s),
    .idx (enc_idx_s)
  );

  // FSM state register together with the registered in-service outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      irq_id_r    <= '0;
      irq_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      irq_id_r    <= id_nxt_s;
      irq_valid_r <= valid_nxt_s;
    end
  end

  // FSM next state: no preemption while in service, only ack returns to IDLE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enc_any_s) begin
          state_nxt_s = ST_SERVICE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (irq_ack) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SERVICE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: latch the winner on entry, hold irq_id frozen while in service
  always_comb begin
    id_nxt_s    = irq_id_r;
    valid_nxt_s = irq_valid_r;
    case (state_r)
      ST_IDLE: begin
        if (enc_any_s) begin
          id_nxt_s    = enc_idx_s;
          valid_nxt_s = 1'b1;
        end else begin
          valid_nxt_s = 1'b0;
        end
      end
      ST_SERVICE: begin
        if (irq_ack) begin
          valid_nxt_s = 1'b0;
        end else begin
          valid_nxt_s = 1'b1;
        end
      end
      default: begin
        id_nxt_s    = '0;
        valid_nxt_s = 1'b0;
      end
    endcase
  end

  // Register read mux; unused offsets read zero
  always_comb begin
    rd_s = '0;
    case (addr_s)
      REG_MASK: rd_s[N_SRC-1:0] = mask_r;
      REG_MODE: rd_s[N_SRC-1:0] = mode_r;
      REG_PEND: rd_s[N_SRC-1:0] = pend_r;
      REG_STATUS: begin
        rd_s[ID_W-1:0] = irq_id_r;
        rd_s[ID_W]     = irq_valid_r;
      end
      default: rd_s = '0;
    endcase
  end

  assign bus_rd    = rd_s;
  assign int_out   = int_out_r;
  assign irq_valid = irq_valid_r;
  assign irq_id    = irq_id_r;

endmodule

// File: tb/tb_mips_irq_ctrl.sv
// Directed self-checking bench for mips_irq_ctrl with default parameters.
// Latency expectations adapt when IRQ_SYNC_EN is defined.
`timescale 1ns/1ps
module tb_mips_irq_ctrl;

`ifdef IRQ_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq_src;
  logic        bus_we;
  logic [2:0]  bus_addr;
  logic [31:0] bus_wd;
  logic [31:0] bus_rd;
  logic [4:0]  int_out;
  logic        irq_valid;
  logic [2:0]  irq_id;
  logic        irq_ack;

  int checks   = 0;
  int failures = 0;
  logic [31:0] v;

  mips_irq_ctrl dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wd(bus_wd), .bus_rd(bus_rd), .int_out(int_out), .irq_valid(irq_valid),
    .irq_id(irq_id), .irq_ack(irq_ack)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus_we = 1'b1; bus_addr = a; bus_wd = d;
    tick();
    bus_we = 1'b0; bus_wd = 32'd0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    bus_addr = a;
    #1;
    d = bus_rd;
  endtask

  task automatic pulse(input int idx);
    irq_src[idx] = 1'b1;
    tick();
    irq_src[idx] = 1'b0;
    repeat (SYNC_LAT) tick();
  endtask

  task automatic do_ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (int_out !== 5'd0) begin failures++; $display("FAIL rst_int_out got=%h exp=%h", int_out, 5'd0); end
    checks++; if (irq_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%h exp=%h", irq_valid, 1'b0); end
    rst = 1'b1;
    tick();
    rd(3'd0, v); checks++; if (v !== 32'd0) begin failures++; $display("FAIL rst_mask got=%h exp=%h", v, 32'd0); end
    rd(3'd1, v); checks++; if (v !== 32'd0) begin failures++; $display("FAIL rst_mode got=%h exp=%h", v, 32'd0); end
    rd(3'd2, v); checks++; if (v !== 32'd0) begin failures++; $display("FAIL rst_pend got=%h exp=%h", v, 32'd0); end
    rd(3'd3, v); checks++; if (v !== 32'd0) begin failures++; $display("FAIL rst_status got=%h exp=%h", v, 32'd0); end
    wr(3'd0, 32'hFFFF_FFFF);
    rd(3'd0, v); checks++; if (v !== 32'h0000_00FF) begin failures++; $display("FAIL mask_width got=%h exp=%h", v, 32'hFF); end
    rd(3'd6, v); checks++; if (v !== 32'd0) begin failures++; $display("FAIL unused_addr got=%h exp=%h", v, 32'd0); end
  endtask

  task automatic test_edge();
    wr(3'd0, 32'hFF);
    wr(3'd1, 32'hFF);
    pulse(3);
    rd(3'd2, v); checks++; if (v !== 32'h08) begin failures++; $display("FAIL edge_pend got=%h exp=%h", v, 32'h08); end
    checks++; if (irq_valid !== 1'b0) begin failures++; $display("FAIL edge_valid_early got=%h exp=%h", irq_valid, 1'b0); end
    tick();
    checks++; if (irq_valid !== 1'b1) begin failures++; $display("FAIL edge_valid got=%h exp=%h", irq_valid, 1'b1); end
    checks++; if (irq_id !== 3'd3) begin failures++; $display("FAIL edge_id got=%h exp=%h", irq_id, 3'd3); end
    checks++; if (int_out !== 5'b01000) begin failures++; $display("FAIL edge_int_out got=%h exp=%h", int_out, 5'b01000); end
    rd(3'd3, v); checks++; if (v !== 32'h0B) begin failures++; $display("FAIL edge_status got=%h exp=%h", v, 32'h0B); end
    do_ack();
    rd(3'd2, v); checks++; if (v !== 32'h00) begin failures++; $display("FAIL ack_pend got=%h exp=%h", v, 32'h00); end
    checks++; if (irq_valid !== 1'b0) begin failures++; $display("FAIL ack_valid got=%h exp=%h", irq_valid, 1'b0); end
    tick();
    checks++; if (int_out !== 5'd0) begin failures++; $display("FAIL ack_int_out got=%h exp=%h", int_out, 5'd0); end
  endtask

  task automatic test_priority();
    pulse(5);
    tick();
    checks++; if (irq_id !== 3'd5 || irq_valid !== 1'b1) begin failures++; $display("FAIL prio_first got=%h/%h exp=5/1", irq_id, irq_valid); end
    pulse(1);
    rd(3'd2, v); checks++; if (v !== 32'h22) begin failures++; $display("FAIL prio_pend got=%h exp=%h", v, 32'h22); end
    tick();
    checks++; if (irq_id !== 3'd5) begin failures++; $display("FAIL prio_no_preempt got=%h exp=%h", irq_id, 3'd5); end
    checks++; if (int_out !== 5'b00011) begin failures++; $display("FAIL prio_int_out got=%h exp=%h", int_out, 5'b00011); end
    do_ack();
    checks++; if (irq_valid !== 1'b0) begin failures++; $display("FAIL prio_ack_valid got=%h exp=%h", irq_valid, 1'b0); end
    rd(3'd2, v); checks++; if (v !== 32'h02) begin failures++; $display("FAIL prio_ack_pend got=%h exp=%h", v, 32'h02); end
    tick();
    checks++; if (irq_id !== 3'd1 || irq_valid !== 1'b1) begin failures++; $display("FAIL prio_second got=%h/%h exp=1/1", irq_id, irq_valid); end
    do_ack();
    rd(3'd2, v); checks++; if (v !== 32'h00) begin failures++; $display("FAIL prio_end_pend got=%h exp=%h", v, 32'h00); end
  endtask

  task automatic test_level();
    wr(3'd1, 32'h00);
    irq_src[6] = 1'b1;
    tick();
    repeat (SYNC_LAT) tick();
    rd(3'd2, v); checks++; if (v !== 32'h40) begin failures++; $display("FAIL lvl_pend got=%h exp=%h", v, 32'h40); end
    tick();
    checks++; if (irq_id !== 3'd6 || irq_valid !== 1'b1) begin failures++; $display("FAIL lvl_service got=%h/%h exp=6/1", irq_id, irq_valid); end
    checks++; if (int_out !== 5'b00010) begin failures++; $display("FAIL lvl_int_out got=%h exp=%h", int_out, 5'b00010); end
    bus_we = 1'b1; bus_addr = 3'd2; bus_wd = 32'h40; irq_ack = 1'b1;
    tick();
    bus_we = 1'b0; bus_wd = 32'd0; irq_ack = 1'b0;
    rd(3'd2, v); checks++; if (v !== 32'h40) begin failures++; $display("FAIL lvl_w1c_ack_pend got=%h exp=%h", v, 32'h40); end
    checks++; if (irq_valid !== 1'b0) begin failures++; $display("FAIL lvl_ack_valid got=%h exp=%h", irq_valid, 1'b0); end
    tick();
    checks++; if (irq_valid !== 1'b1) begin failures++; $display("FAIL lvl_rearb got=%h exp=%h", irq_valid, 1'b1); end
    irq_src[6] = 1'b0;
    tick();
    repeat (SYNC_LAT) tick();
    rd(3'd2, v); checks++; if (v !== 32'h00) begin failures++; $display("FAIL lvl_drop_pend got=%h exp=%h", v, 32'h00); end
    tick();
    checks++; if (int_out !== 5'd0) begin failures++; $display("FAIL lvl_drop_int_out got=%h exp=%h", int_out, 5'd0); end
    checks++; if (irq_valid !== 1'b1) begin failures++; $display("FAIL lvl_hold_service got=%h exp=%h", irq_valid, 1'b1); end
    do_ack();
    tick();
    checks++; if (irq_valid !== 1'b0) begin failures++; $display("FAIL lvl_idle got=%h exp=%h", irq_valid, 1'b0); end
  endtask

  task automatic test_mask_wrap();
    wr(3'd1, 32'hFF);
    wr(3'd0, 32'h00);
    pulse(7);
    rd(3'd2, v); checks++; if (v !== 32'h80) begin failures++; $display("FAIL mask_pend got=%h exp=%h", v, 32'h80); end
    tick();
    checks++; if (int_out !== 5'd0 || irq_valid !== 1'b0) begin failures++; $display("FAIL masked_quiet got=%h/%h exp=0/0", int_out, irq_valid); end
    wr(3'd0, 32'h80);
    tick();
    checks++; if (int_out !== 5'b00100) begin failures++; $display("FAIL wrap_int_out got=%h exp=%h", int_out, 5'b00100); end
    checks++; if (irq_id !== 3'd7 || irq_valid !== 1'b1) begin failures++; $display("FAIL wrap_service got=%h/%h exp=7/1", irq_id, irq_valid); end
    irq_src[7] = 1'b1;
    repeat (SYNC_LAT) tick();
    wr(3'd2, 32'h80);
    irq_src[7] = 1'b0;
    rd(3'd2, v); checks++; if (v !== 32'h80) begin failures++; $display("FAIL set_wins got=%h exp=%h", v, 32'h80); end
    do_ack();
    rd(3'd2, v); checks++; if (v !== 32'h00) begin failures++; $display("FAIL wrap_ack_pend got=%h exp=%h", v, 32'h00); end
    tick();
    checks++; if (irq_valid !== 1'b0) begin failures++; $display("FAIL wrap_idle got=%h exp=%h", irq_valid, 1'b0); end
  endtask

  task automatic test_reset_mid();
    wr(3'd0, 32'hFF);
    pulse(2);
    tick();
    checks++; if (irq_id !== 3'd2 || irq_valid !== 1'b1) begin failures++; $display("FAIL mid_pre got=%h/%h exp=2/1", irq_id, irq_valid); end
    rst = 1'b0;
    #1;
    checks++; if (int_out !== 5'd0 || irq_valid !== 1'b0 || irq_id !== 3'd0) begin failures++; $display("FAIL mid_rst_out got=%h/%h/%h exp=0/0/0", int_out, irq_valid, irq_id); end
    rd(3'd2, v); checks++; if (v !== 32'd0) begin failures++; $display("FAIL mid_rst_pend got=%h exp=%h", v, 32'd0); end
    rd(3'd0, v); checks++; if (v !== 32'd0) begin failures++; $display("FAIL mid_rst_mask got=%h exp=%h", v, 32'd0); end
    tick();
    rst = 1'b1;
    tick();
    checks++; if (irq_valid !== 1'b0) begin failures++; $display("FAIL post_rst_valid got=%h exp=%h", irq_valid, 1'b0); end
  endtask

  initial begin
    rst = 1'b0; irq_src = 8'd0; bus_we = 1'b0; bus_addr = 3'd0; bus_wd = 32'd0; irq_ack = 1'b0;
    #1;
    tick();
    tick();
    test_reset();
    test_edge();
    test_priority();
    test_level();
    test_mask_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
